// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_pkg
// Purpose : Shared constants and the IF/ID pipeline-register type for the
//           instruction-fetch stage.
// Contents: RESET_PC_DEFAULT, IMEM_BASE_DEFAULT, IMEM_LIMIT_DEFAULT, if_id_t
// Config  : none (IFETCH_DELAY_SLOT_EN is consumed by ifetch_unit)
// Revision: 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT_DEFAULT = 32'h0000_4003;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc8;
    } if_id_t;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/ifetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_pc_gen
// Purpose : Program-counter register and next-PC selection.
//           Priority per edge: redirect > stall > advance by 4.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           stall             - hold the PC
//           redirect          - load the PC from the redirect target
//           redirect_word     - target address bits [31:2] (word aligned)
//           pc                - current PC (registered)
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_pc_gen
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [29:0] redirect_word,
    output logic [31:0] pc
);

    logic [31:0] r_pc;

    // The low two target bits are dropped here; misalignment is reported by
    // the parent as a fault, while the PC stays word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= {redirect_word, 2'b00};
        end else if (!stall) begin
            r_pc <= r_pc + 32'd4;   // wraps silently at 2^32
        end
    end

    assign pc = r_pc;

endmodule : ifetch_pc_gen
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_unit
// Purpose : Instruction-fetch stage. Drives the instruction-memory address
//           straight from the PC register, captures the returned word into
//           the IF/ID register one edge later, range-checks every fetch and
//           keeps a sticky fault flag.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           stall             - hold PC and IF/ID
//           redirect          - branch/jump taken, load PC from redirect_pc
//           redirect_pc[31:0] - target byte address
//           ins_addr[31:0]    - instruction memory read address
//           ins[31:0]         - instruction word for ins_addr (combinational)
//           if_id_valid/pc/ins/pc8 - IF/ID register outputs
//           fetch_fault       - sticky misaligned-redirect / range fault
// Config  : IFETCH_DELAY_SLOT_EN - when defined, an unstalled redirect edge
//           captures the current fetch as a delay slot instead of squashing.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEFAULT,
    parameter logic [31:0] IMEM_LIMIT = IMEM_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ins_addr,
    input  logic [31:0] ins,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_ins,
    output logic [31:0] if_id_pc8,
    output logic        fetch_fault
);

    logic [31:0] w_pc;
    logic [31:0] w_pc8;
    logic        w_out_of_range;
    logic        w_misaligned;
    logic        w_capture;
    if_id_t      r_if_id;
    logic        r_fault;

    ifetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_word (redirect_pc[31:2]),
        .pc            (w_pc)
    );

    assign ins_addr       = w_pc;
    assign w_pc8          = w_pc + 32'd8;
    assign w_out_of_range = (w_pc < IMEM_BASE) || (w_pc > IMEM_LIMIT);
    assign w_misaligned   = redirect && (redirect_pc[1:0] != 2'b00);

    // Edges on which IF/ID takes the word currently being fetched.
`ifdef IFETCH_DELAY_SLOT_EN
    assign w_capture = !stall;
`else
    assign w_capture = !stall && !redirect;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_capture) begin
                if (w_out_of_range) begin
                    // Bubble: only valid drops, the payload fields hold.
                    r_if_id.valid <= 1'b0;
                end else begin
                    r_if_id <= '{valid: 1'b1, pc: w_pc, ins: ins, pc8: w_pc8};
                end
            end
`ifndef IFETCH_DELAY_SLOT_EN
            else if (redirect) begin
                // Squash the wrong-path fetch even when stalled.
                r_if_id.valid <= 1'b0;
            end
`endif
            if (w_misaligned || (w_capture && w_out_of_range)) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign if_id_valid = r_if_id.valid;
    assign if_id_pc    = r_if_id.pc;
    assign if_id_ins   = r_if_id.ins;
    assign if_id_pc8   = r_if_id.pc8;
    assign fetch_fault = r_fault;

endmodule : ifetch_unit
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifetch_unit
// Purpose : Self-checking bench for ifetch_unit. A behavioural model of the
//           fetch stage pushes expected outputs per edge into a scoreboard
//           queue; after each edge the entry is popped and compared. Directed
//           checks cover reset, stall, redirect, fault and range boundaries.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc8;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ins_addr;
    logic [31:0] ins;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_ins;
    logic [31:0] if_id_pc8;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_err = 0;

    exp_t sb_q[$];

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_iins;
    logic [31:0] m_ipc8;
    logic        m_fault;

    ifetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_addr    (ins_addr),
        .ins         (ins),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_ins   (if_id_ins),
        .if_id_pc8   (if_id_pc8),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at 0x3000, address-derived elsewhere
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2008_0001;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign ins = imem(ins_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_valid = 1'b0;
        m_ipc   = 32'h0;
        m_iins  = 32'h0;
        m_ipc8  = 32'h0;
        m_fault = 1'b0;
        sb_q.delete();
    endtask

    // One clock edge of the reference fetch stage.
    task automatic model_edge(input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] cur_ins;
        logic        oor;
        logic        take;
        cur_ins = imem(m_pc);
        oor     = (m_pc < 32'h0000_3000) || (m_pc > 32'h0000_4003);
        if (rd && (rpc[1:0] != 2'b00)) m_fault = 1'b1;
`ifdef IFETCH_DELAY_SLOT_EN
        take = !st;
`else
        take = !st && !rd;
        if (rd) m_valid = 1'b0;
`endif
        if (take) begin
            if (oor) begin
                m_valid = 1'b0;
                m_fault = 1'b1;
            end else begin
                m_valid = 1'b1;
                m_ipc   = m_pc;
                m_iins  = cur_ins;
                m_ipc8  = m_pc + 32'd8;
            end
        end
        if (rd)       m_pc = {rpc[31:2], 2'b00};
        else if (!st) m_pc = m_pc + 32'd4;
    endtask

    // Drive inputs (called just after an edge), predict, clock, then score.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        exp_t e;
        exp_t g;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        model_edge(st, rd, rpc);
        e.addr  = m_pc;
        e.valid = m_valid;
        e.pc    = m_ipc;
        e.ins   = m_iins;
        e.pc8   = m_ipc8;
        e.fault = m_fault;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        chk("sb_ins_addr", ins_addr, g.addr);
        chk("sb_valid",    {31'b0, if_id_valid}, {31'b0, g.valid});
        chk("sb_if_id_pc", if_id_pc, g.pc);
        chk("sb_if_id_ins", if_id_ins, g.ins);
        chk("sb_if_id_pc8", if_id_pc8, g.pc8);
        chk("sb_fault",    {31'b0, fetch_fault}, {31'b0, g.fault});
        stall    = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"},  ins_addr, 32'h0000_3000);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        chk({tag, "_pc"},    if_id_pc, 32'h0);
        chk({tag, "_ins"},   if_id_ins, 32'h0);
        chk({tag, "_pc8"},   if_id_pc8, 32'h0);
        chk({tag, "_fault"}, {31'b0, fetch_fault}, 32'h0);
    endtask

    // Asynchronous reset pulse placed between edges (called at posedge+1).
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_values(tag);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();

        // Reset state while held
        #7 check_reset_values("rst");
        #1 rst_n = 1'b1;

        // First fetch after release
        step(1'b0, 1'b0, 32'h0);
        chk("first_valid", {31'b0, if_id_valid}, 32'h1);
        chk("first_pc",    if_id_pc,  32'h0000_3000);
        chk("first_ins",   if_id_ins, 32'h2008_0001);
        chk("first_pc8",   if_id_pc8, 32'h0000_3008);
        chk("first_addr",  ins_addr,  32'h0000_3004);

        // Advance to 0x3008 then stall 3 cycles
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("stall_addr", ins_addr, 32'h0000_3008);
            chk("stall_pc",   if_id_pc, 32'h0000_3004);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("resume_addr", ins_addr, 32'h0000_300C);
        chk("resume_pc",   if_id_pc, 32'h0000_3008);

        // Stalled redirect at PC=0x3010
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_3040);
        chk("redir_addr", ins_addr, 32'h0000_3040);
`ifdef IFETCH_DELAY_SLOT_EN
        chk("redir_valid", {31'b0, if_id_valid}, 32'h1);
        chk("redir_pc",    if_id_pc, 32'h0000_300C);
`else
        chk("redir_valid", {31'b0, if_id_valid}, 32'h0);
`endif

        // Unstalled redirect (delay-slot behaviour differs by build)
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_3080);
        chk("redir2_addr", ins_addr, 32'h0000_3080);

        // Misaligned redirect -> sticky fault
        step(1'b0, 1'b1, 32'h0000_3042);
        chk("mis_addr",  ins_addr, 32'h0000_3040);
        chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
        for (int i = 0; i < 4; i++) step(i[0], 1'b0, 32'h0);
        chk("mis_sticky", {31'b0, fetch_fault}, 32'h1);
        reset_pulse("rst_fault");

        // Upper range boundary
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_4000);
        step(1'b0, 1'b0, 32'h0);
        chk("lim_valid", {31'b0, if_id_valid}, 32'h1);
        chk("lim_pc",    if_id_pc, 32'h0000_4000);
        chk("lim_fault", {31'b0, fetch_fault}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("oor_valid", {31'b0, if_id_valid}, 32'h0);
        chk("oor_fault", {31'b0, fetch_fault}, 32'h1);
        chk("oor_addr",  ins_addr, 32'h0000_4008);
        reset_pulse("rst_oor");

        // Below-base fetch and silent wrap at 2^32
        step(1'b0, 1'b1, 32'h0000_2FFC);
        step(1'b0, 1'b0, 32'h0);
        chk("low_valid", {31'b0, if_id_valid}, 32'h0);
        chk("low_fault", {31'b0, fetch_fault}, 32'h1);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_addr", ins_addr, 32'h0000_0000);
        step(1'b0, 1'b0, 32'h0);
        reset_pulse("rst_wrap");

        // Reset mid-stall/redirect at PC=0x3020
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
        chk("pre_rst_addr", ins_addr, 32'h0000_3020);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3100;
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_mid");
        stall    = 1'b0;
        redirect = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 32'h0);
        chk("post_rst_pc", if_id_pc, 32'h0000_3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ifetch_unit
`default_nettype wire
